// File: rtl/fir_xifu_scoreboard.sv
// fir_xifu_scoreboard: tracks in-flight XIFU instructions, gating issue on register
// hazards and id reuse, and gating EX on commit status.
module fir_xifu_scoreboard #(
    parameter int NB_REGS    = 4,
    parameter int NB_ENTRIES = 4,
    parameter int ID_WIDTH   = 4,
    localparam int RW = (NB_REGS > 1) ? $clog2(NB_REGS) : 1,
    localparam int CW = $clog2(NB_ENTRIES + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [RW-1:0]       issue_rd_i,
    input  logic                issue_we_i,
    input  logic [2*RW-1:0]     issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    input  logic [ID_WIDTH-1:0] ex_id_i,
    output logic                ex_go_o,
    input  logic                retire_valid_i,
    input  logic [ID_WIDTH-1:0] retire_id_i,
    output logic                full_o,
    output logic                empty_o,
    output logic [CW-1:0]       count_o,
    output logic                err_o
);
    logic [NB_ENTRIES-1:0] slot_valid, slot_we, slot_cm;
    logic [ID_WIDTH-1:0]   slot_id [NB_ENTRIES];
    logic [RW-1:0]         slot_rd [NB_ENTRIES];
    logic [NB_ENTRIES-1:0] valid_n, cm_n, free_oh, commit_hit, retire_hit;
    logic [CW-1:0]         count_q, count_n;
    logic                  err_q, err_n, hazard, id_held, found, accept, same_c, go;

    always_comb begin
        hazard = 1'b0;
        id_held = 1'b0;
        found = 1'b0;
        go = 1'b0;
        free_oh = '0;
        commit_hit = '0;
        retire_hit = '0;
        for (int i = 0; i < NB_ENTRIES; i++) begin
            if (slot_valid[i] && slot_we[i] &&
                ((issue_rs_valid_i[0] && slot_rd[i] == issue_rs_i[RW-1:0]) ||
                 (issue_rs_valid_i[1] && slot_rd[i] == issue_rs_i[2*RW-1:RW]) ||
                 (issue_we_i && slot_rd[i] == issue_rd_i)))
                hazard = 1'b1;
            if (slot_valid[i] && slot_id[i] == issue_id_i) id_held = 1'b1;
            if (slot_valid[i] && slot_cm[i] && slot_id[i] == ex_id_i) go = 1'b1;
            free_oh[i] = !slot_valid[i] && !found;
            found = found || !slot_valid[i];
            commit_hit[i] = commit_valid_i && slot_valid[i] && slot_id[i] == commit_id_i;
            retire_hit[i] = retire_valid_i && slot_valid[i] && slot_cm[i] && slot_id[i] == retire_id_i;
        end
        accept = rst_ni && issue_valid_i && !full_o && !hazard && !id_held && !clear_i;
        same_c = accept && commit_valid_i && commit_id_i == issue_id_i;
        valid_n = slot_valid;
        cm_n = slot_cm;
        for (int i = 0; i < NB_ENTRIES; i++) begin
            if (commit_hit[i]) begin
                valid_n[i] = valid_n[i] && !commit_kill_i;
                cm_n[i] = cm_n[i] || !commit_kill_i;
            end
            if (retire_hit[i]) valid_n[i] = 1'b0;
            if (accept && free_oh[i]) begin
                valid_n[i] = !(same_c && commit_kill_i);
                cm_n[i] = same_c && !commit_kill_i;
            end
        end
        if (clear_i) valid_n = '0;
        count_n = '0;
        for (int i = 0; i < NB_ENTRIES; i++) count_n = count_n + CW'(valid_n[i]);
        err_n = !clear_i && ((commit_valid_i && commit_hit == '0 && !same_c) ||
                             (retire_valid_i && retire_hit == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_valid <= '0;
            slot_cm <= '0;
            slot_we <= '0;
            count_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < NB_ENTRIES; i++) begin
                slot_id[i] <= '0;
                slot_rd[i] <= '0;
            end
        end else begin
            slot_valid <= valid_n;
            slot_cm <= cm_n;
            count_q <= count_n;
            err_q <= err_n;
            for (int i = 0; i < NB_ENTRIES; i++)
                if (accept && free_oh[i]) begin
                    slot_id[i] <= issue_id_i;
                    slot_rd[i] <= issue_rd_i;
                    slot_we[i] <= issue_we_i;
                end
        end
    end

    assign issue_ready_o = accept;
    assign ex_go_o = go;
    assign count_o = count_q;
    assign err_o = err_q;
    assign full_o = count_q == CW'(NB_ENTRIES);
    assign empty_o = count_q == '0;
endmodule

// File: tb/tb_fir_xifu_scoreboard.sv
// tb_fir_xifu_scoreboard: directed checks of issue gating, commit/kill/retire and flush/reset.
module tb_fir_xifu_scoreboard;
  logic       clk = 0, rst_ni = 0, clear_i = 0;
  logic       issue_valid_i = 0, issue_ready_o, issue_we_i = 0;
  logic [3:0] issue_id_i = 0, commit_id_i = 0, ex_id_i = 0, retire_id_i = 0;
  logic [1:0] issue_rd_i = 0, issue_rs_valid_i = 0;
  logic [3:0] issue_rs_i = 0;
  logic       commit_valid_i = 0, commit_kill_i = 0, ex_go_o, retire_valid_i = 0;
  logic       full_o, empty_o, err_o;
  logic [2:0] count_o;
  logic       done = 0;
  int total = 0, bad = 0;
  fir_xifu_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i), .issue_rs_i(issue_rs_i),
    .issue_rs_valid_i(issue_rs_valid_i), .commit_valid_i(commit_valid_i),
    .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i), .ex_id_i(ex_id_i),
    .ex_go_o(ex_go_o), .retire_valid_i(retire_valid_i), .retire_id_i(retire_id_i),
    .full_o(full_o), .empty_o(empty_o), .count_o(count_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    clear_i = 0; issue_valid_i = 0; issue_we_i = 0; issue_rs_valid_i = 0; issue_rs_i = 0;
    commit_valid_i = 0; commit_kill_i = 0; retire_valid_i = 0;
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic issue(input logic [3:0] id, input logic [1:0] rd, input logic we);
    issue_valid_i = 1; issue_id_i = id; issue_rd_i = rd; issue_we_i = we;
  endtask
  initial begin
    #100000;
    if (!done) begin
      total++; bad++;
      $error("FAIL timeout: wait expired before test completion");
      $finish;
    end
  end
  initial begin
    issue(4'd1, 2'd0, 1'b1);
    #2;
    check("rst_count", count_o, 3'd0);
    check("rst_empty", empty_o, 1'b1);
    check("rst_full", full_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_ready", issue_ready_o, 1'b0);
    check("rst_exgo", ex_go_o, 1'b0);
    @(negedge clk); rst_ni = 1; #1;
    for (int i = 1; i <= 4; i++) begin
      issue(4'(i), 2'(i - 1), 1'b1); #1;
      check("fill_ready", issue_ready_o, 1'b1);
      tick(); idle();
    end
    check("fill_count", count_o, 3'd4);
    check("fill_full", full_o, 1'b1);
    issue(4'd5, 2'd0, 1'b0); #1;
    check("full_reject", issue_ready_o, 1'b0);
    idle(); ex_id_i = 4'd1; #1;
    check("exgo_uncommitted", ex_go_o, 1'b0);
    commit_valid_i = 1; commit_id_i = 4'd1; tick(); idle(); #1;
    check("exgo_committed", ex_go_o, 1'b1);
    check("commit_noerr", err_o, 1'b0);
    retire_valid_i = 1; retire_id_i = 4'd1; issue(4'd8, 2'd0, 1'b0); #1;
    check("retire_issue_reject", issue_ready_o, 1'b0);
    tick(); idle();
    check("retire_count", count_o, 3'd3);
    issue(4'd8, 2'd0, 1'b0); #1;
    check("reissue_ready", issue_ready_o, 1'b1);
    tick(); idle();
    check("reissue_slot0", dut.slot_id[0], 4'd8);
    check("reissue_count", count_o, 3'd4);
    commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 4'd2; tick(); idle();
    check("kill_count", count_o, 3'd3);
    clear_i = 1; issue(4'd10, 2'd3, 1'b0); #1;
    check("clear_ready", issue_ready_o, 1'b0);
    tick(); idle();
    check("clear_count", count_o, 3'd0);
    check("clear_empty", empty_o, 1'b1);
    issue(4'd2, 2'd1, 1'b1); #1;
    check("raw_prod_ready", issue_ready_o, 1'b1);
    tick(); idle();
    issue(4'd3, 2'd0, 1'b0); issue_rs_i = 4'b0001; issue_rs_valid_i = 2'b01; #1;
    check("raw_block0", issue_ready_o, 1'b0);
    tick();
    check("raw_block1", issue_ready_o, 1'b0);
    commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 4'd2; #1;
    check("raw_block_kill", issue_ready_o, 1'b0);
    tick(); commit_valid_i = 0; commit_kill_i = 0; #1;
    check("raw_release", issue_ready_o, 1'b1);
    tick(); idle();
    check("raw_count", count_o, 3'd1);
    commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 4'd3; tick(); idle();
    check("kill3_count", count_o, 3'd0);
    issue(4'd7, 2'd0, 1'b1); commit_valid_i = 1; commit_id_i = 4'd7; #1;
    check("samecyc_ready", issue_ready_o, 1'b1);
    tick(); idle(); ex_id_i = 4'd7; #1;
    check("samecyc_exgo", ex_go_o, 1'b1);
    check("samecyc_noerr", err_o, 1'b0);
    check("samecyc_count", count_o, 3'd1);
    retire_valid_i = 1; retire_id_i = 4'd7; tick(); idle();
    check("retire7_count", count_o, 3'd0);
    check("retire7_noerr", err_o, 1'b0);
    retire_valid_i = 1; retire_id_i = 4'd9; tick(); idle();
    check("bad_retire_err", err_o, 1'b1);
    check("bad_retire_count", count_o, 3'd0);
    tick();
    check("bad_retire_pulse", err_o, 1'b0);
    commit_valid_i = 1; commit_id_i = 4'd12; tick(); idle();
    check("bad_commit_err", err_o, 1'b1);
    issue(4'd1, 2'd2, 1'b1); tick(); idle();
    issue(4'd2, 2'd2, 1'b1); #1;
    check("waw_block", issue_ready_o, 1'b0);
    issue_we_i = 0; #1;
    check("waw_nowrite", issue_ready_o, 1'b1);
    tick(); idle();
    check("waw_count", count_o, 3'd2);
    issue(4'd1, 2'd3, 1'b0); #1;
    check("dup_id_block", issue_ready_o, 1'b0);
    issue(4'd3, 2'd2, 1'b1); retire_valid_i = 1; retire_id_i = 4'd1; #1;
    check("no_retire_bypass", issue_ready_o, 1'b0);
    tick(); idle();
    check("uncommitted_retire_err", err_o, 1'b1);
    check("uncommitted_retire_count", count_o, 3'd2);
    issue(4'd5, 2'd0, 1'b0); commit_valid_i = 1; commit_kill_i = 1; commit_id_i = 4'd5; #1;
    check("samecyc_kill_ready", issue_ready_o, 1'b1);
    tick(); idle();
    check("samecyc_kill_count", count_o, 3'd2);
    check("samecyc_kill_noerr", err_o, 1'b0);
    issue(4'd6, 2'd0, 1'b0); #1;
    rst_ni = 0; #1;
    check("midrst_count", count_o, 3'd0);
    check("midrst_empty", empty_o, 1'b1);
    check("midrst_ready", issue_ready_o, 1'b0);
    @(negedge clk); rst_ni = 1; #1;
    check("postrst_ready", issue_ready_o, 1'b1);
    tick(); idle();
    check("postrst_count", count_o, 3'd1);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_xifu_scoreboard.md
FIR_XIFU_SCOREBOARD -- requirements
Module: fir_xifu_scoreboard

Interface
REQ-001 SHALL have parameter NB_REGS, default 4: number of XIFU registers tracked for hazards.
REQ-002 SHALL have parameter NB_ENTRIES, default 4: in-flight instruction slots.
REQ-003 SHALL have parameter ID_WIDTH, default 4: XIF instruction id width; RW = $clog2(NB_REGS), CW = $clog2(NB_ENTRIES+1).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
clear_i  in  1  synchronous flush of all entries
issue_valid_i  in  1  instruction offered by ID
issue_ready_o  out  1  offer accepted this cycle
issue_id_i  in  ID_WIDTH  instruction id
issue_rd_i  in  RW  destination register
issue_we_i  in  1  instruction writes rd
issue_rs_i  in  2*RW  source registers {rs2,rs1}
issue_rs_valid_i  in  2  source register used
commit_valid_i  in  1  commit/kill event
commit_id_i  in  ID_WIDTH  committed id
commit_kill_i  in  1  1=kill, 0=commit
ex_id_i  in  ID_WIDTH  id queried by EX
ex_go_o  out  1  queried id present and committed
retire_valid_i  in  1  WB completion
retire_id_i  in  ID_WIDTH  completed id
full_o  out  1  no free slot
empty_o  out  1  no valid slot
count_o  out  CW  valid slots
err_o  out  1  one-cycle protocol-error pulse

Function
REQ-006 SHALL hold NB_ENTRIES slots, each {valid, id, rd, we, committed}.
REQ-007 Hazard SHALL be asserted when any valid slot with we=1 has rd equal to a used rs (RAW) or to issue_rd_i while issue_we_i=1 (WAW).
REQ-008 issue_ready_o SHALL equal issue_valid_i AND NOT full AND NOT hazard AND NOT (id already held by a valid slot); combinational on current state only, no same-cycle retire bypass.
REQ-009 On accept, SHALL write the lowest-index free slot at the next edge with committed=0.
REQ-010 Commit (kill=0) matching a valid slot SHALL set committed=1 at the next edge.
REQ-011 Kill (kill=1) matching a valid slot SHALL clear valid at the next edge, releasing its hazard.
REQ-012 Commit/kill with same id as a same-cycle accepted issue SHALL apply to the new slot: commit writes committed=1, kill writes nothing.
REQ-013 Commit/kill matching no slot and not the accepted issue SHALL be ignored and pulse err_o next cycle.
REQ-014 Retire matching a valid committed slot SHALL clear valid at the next edge; retire to an absent or uncommitted id SHALL be ignored and pulse err_o next cycle.
REQ-015 Issue accept, commit and retire to different slots in one cycle SHALL all take effect.
REQ-016 ex_go_o SHALL be combinational: 1 iff a valid slot with id=ex_id_i has committed=1.
REQ-017 count_o SHALL be registered, incremented/decremented per accepted issue/freed slot, range 0..NB_ENTRIES, never wrapping; full_o = (count_o==NB_ENTRIES), empty_o = (count_o==0).
REQ-018 clear_i SHALL clear all valid bits and count_o at the next edge, overriding same-cycle issue, commit and retire; issue_ready_o SHALL be 0 while clear_i=1.

Reset
REQ-019 On rst_ni=0 SHALL immediately clear all slots, count_o=0, empty_o=1, full_o=0, err_o=0, issue_ready_o=0, ex_go_o=0, regardless of in-flight state.
REQ-020 After reset release SHALL accept issue on the first cycle.

Verification
REQ-021 Issue ids 1..4 (rd 0..3, we=1, no rs) with no retire -> count_o=4, full_o=1; 5th issue id 5 -> issue_ready_o=0.
REQ-022 Issue id 2 rd=1 we=1, then id 3 rs1=1 -> ready=0 until kill id 2, then ready=1 next cycle.
REQ-023 Issue id 7 with commit id 7 kill=0 same cycle, ex_id_i=7 next cycle -> ex_go_o=1; retire id 7 -> count_o back to 0.
REQ-024 Retire id 9 never issued -> err_o=1 for exactly one cycle, count_o unchanged.
REQ-025 Full table, retire id 1 and issue id 8 same cycle -> issue rejected; reissue next cycle accepted into slot 0.
REQ-026 Three slots valid, assert clear_i with simultaneous issue -> count_o=0, empty_o=1 next cycle; reset mid-operation -> same.
